mem_tracker: RTL and testbench

Parametrised synchronous successor to the DMA shared-bus memory. It is a single-port word memory on the tristate `databus`, selected by the MSB of `index`, with a `ready`/`ack` handshake and registered reads. It also has an incremental first-empty tracker with a `memfull` flag, exposed as ports and as a read-only status word. It sits on the DMA data bus as source/destination memory.

---
 rtl/mem_tracker.sv | 137 +++++++++++++
 tb/tb_mem_tracker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tracker.sv
// Single-port word memory on a shared tristate bus with a ready/ack handshake and
// an incremental first-empty tracker, also readable as the top (status) word.
module mem_tracker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 192,
  parameter int INIT_COUNT = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memWR,
  input  logic [ADDR_W:0]   index,
  inout  wire  [DATA_W-1:0] databus,
  output logic              ready,
  output logic              ack,
  output logic [ADDR_W-1:0] firstempty,
  output logic              memfull
);

  localparam int MW = $clog2(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] INIT_N   = ADDR_W'(INIT_COUNT);
  localparam bit                FULL_RST = (INIT_COUNT > DEPTH - 2);
  localparam logic [ADDR_W-1:0] FE_RST   = FULL_RST ? STATUS_A :
                                           (INIT_COUNT < 1) ? ADDR_W'(1) : INIT_N;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] scan_p;
  logic [DATA_W-1:0] rd_reg;
  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] init_val;
  logic [DATA_W-1:0] scan_word;
  logic [DATA_W-1:0] mem [0:DEPTH-2];

  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_zero;
  logic              in_mem;

  assign cs        = index[ADDR_W];
  assign addr      = index[ADDR_W-1:0];
  assign ready     = (state == S_IDLE);
  assign accept    = cs & ready;
  assign wr_acc    = accept & memWR;
  assign rd_acc    = accept & ~memWR;
  assign wr_zero   = (databus == '0);
  assign in_mem    = (addr < STATUS_A);
  assign init_val  = (init_cnt < INIT_N) ? DATA_W'(init_cnt) + DATA_W'(1) : '0;
  assign scan_word = mem[scan_p[MW-1:0]];

  // The status word is synthesised from the tracker rather than stored.
  assign databus = (cs && !memWR) ? rd_reg : 'z;

  always_comb begin
    // NOTE: default first so no path through this block leaves rd_next unassigned (no latch).
    rd_next = '0;
    if (in_mem)
      rd_next = mem[addr[MW-1:0]];
    else if (addr == STATUS_A)
      rd_next = DATA_W'(firstempty);
  end

  // NOTE: the array has no reset; the INIT sequence rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT)
        mem[init_cnt[MW-1:0]] <= init_val;
      else if (wr_acc && in_mem)
        mem[addr[MW-1:0]] <= databus;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      scan_p     <= '0;
      ack        <= 1'b0;
      rd_reg     <= '0;
      firstempty <= FE_RST;
      memfull    <= FULL_RST;
    end else begin
      ack <= accept;
      case (state)
        S_INIT: begin
          if (init_cnt == LAST_A)
            state <= S_IDLE;
          else
            init_cnt <= init_cnt + 1'b1;
        end
        S_IDLE: begin
          if (rd_acc) begin
            rd_reg <= rd_next;
          end else if (wr_acc) begin
            if (wr_zero && addr != '0 && addr < firstempty) begin
              firstempty <= addr;
              memfull    <= 1'b0;
            end else if (!wr_zero && !memfull && addr == firstempty) begin
              // Filling the last data word cannot reveal a later hole.
              if (addr == LAST_A) begin
                firstempty <= STATUS_A;
                memfull    <= 1'b1;
              end else begin
                scan_p <= addr + 1'b1;
                state  <= S_SCAN;
              end
            end
          end
        end
        S_SCAN: begin
          if (scan_word == '0) begin
            firstempty <= scan_p;
            state      <= S_IDLE;
          end else if (scan_p == LAST_A) begin
            firstempty <= STATUS_A;
            memfull    <= 1'b1;
            state      <= S_IDLE;
          end else begin
            scan_p <= scan_p + 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tracker.sv
// Scoreboard bench for mem_tracker: driver pushes expected read data, a negedge
// monitor pops on every ack; a second instance covers the initially-full case.
module tb_mem_tracker;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 192;
  localparam int INIT_N = 100;
  localparam int BUDGET = 1000;

  typedef struct {
    bit                is_rd;
    int                addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // main instance (default parameters)
  logic              rst = 1'b1;
  logic              cs = 1'b0;
  logic              memWR = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] tb_drv = '0;
  logic              tb_en = 1'b0;
  wire  [ADDR_W:0]   index = {cs, addr};
  wire  [DATA_W-1:0] databus;
  logic              ready, ack, memfull;
  logic [ADDR_W-1:0] firstempty;
  assign databus = tb_en ? tb_drv : 'z;

  mem_tracker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_COUNT(INIT_N)) u_dut (
    .clk(clk), .rst(rst), .memWR(memWR), .index(index), .databus(databus),
    .ready(ready), .ack(ack), .firstempty(firstempty), .memfull(memfull)
  );

  // second instance, initialised full
  logic              f_rst = 1'b1;
  logic              f_cs = 1'b0;
  logic              f_wr = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic [DATA_W-1:0] f_drv = '0;
  logic              f_en = 1'b0;
  wire  [ADDR_W:0]   f_index = {f_cs, f_addr};
  wire  [DATA_W-1:0] f_bus;
  logic              f_ready, f_ack, f_full;
  logic [ADDR_W-1:0] f_fe;
  assign f_bus = f_en ? f_drv : 'z;

  mem_tracker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_COUNT(191)) u_full (
    .clk(clk), .rst(f_rst), .memWR(f_wr), .index(f_index), .databus(f_bus),
    .ready(f_ready), .ack(f_ack), .firstempty(f_fe), .memfull(f_full)
  );

  int                checks = 0;
  int                failures = 0;
  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] mdl [0:DEPTH-2];
  bit                last_rd = 1'b0;
  logic [DATA_W-1:0] zval = 'z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int k = 0; k <= DEPTH - 2; k++)
      mdl[k] = (k < INIT_N) ? DATA_W'(k + 1) : '0;
  endfunction

  function automatic int model_fe();
    for (int i = 1; i <= DEPTH - 2; i++)
      if (mdl[i] == '0) return i;
    return DEPTH - 1;
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int a);
    if (a < DEPTH - 1) return mdl[a];
    if (a == DEPTH - 1) return DATA_W'(model_fe());
    return '0;
  endfunction

  // cycles ready stays low after a write, from the first-empty definition
  function automatic int model_stall(input int a, input logic [DATA_W-1:0] d);
    if (d == '0 || a != model_fe() || a >= DEPTH - 2) return 0;
    for (int j = a + 1; j <= DEPTH - 2; j++)
      if (mdl[j] == '0) return j - a;
    return DEPTH - 2 - a;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0)
        check("ack_unexpected", ack, 0);
      else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd)
          check($sformatf("read_%0d", mon_e.addr), databus, mon_e.data);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic release_bus();
    if (last_rd) begin
      @(negedge clk);
      #1;
      cs      = 1'b0;
      last_rd = 1'b0;
    end
  endtask

  task automatic access(input bit wr, input int a, input logic [DATA_W-1:0] d);
    int   n;
    int   exp_k;
    exp_t e;
    if (wr) release_bus();
    cs = 1'b1; memWR = wr; addr = ADDR_W'(a); tb_drv = d; tb_en = wr;
    n = 0;
    while (!ready && n < BUDGET) begin
      @(posedge clk); #2; n++;
    end
    if (!ready) begin
      check("ready_timeout", ready, 1);
      cs = 1'b0; tb_en = 1'b0; last_rd = 1'b0;
      return;
    end
    e.is_rd = !wr; e.addr = a; e.data = wr ? '0 : model_read(a);
    exp_k = 0;
    if (wr) begin
      exp_k = model_stall(a, d);
      if (a < DEPTH - 1) mdl[a] = d;
    end
    sb.push_back(e);
    @(posedge clk); #2;
    last_rd = !wr;
    if (wr) begin
      cs = 1'b0; tb_en = 1'b0;
      n = 0;
      while (!ready && n < BUDGET) begin
        @(posedge clk); #2; n++;
      end
      check($sformatf("stall_wr_%0d", a), n, exp_k);
      check($sformatf("fe_after_wr_%0d", a), firstempty, model_fe());
      check($sformatf("full_after_wr_%0d", a), memfull, model_fe() == DEPTH - 1);
    end
  endtask

  task automatic idle_cycle();
    release_bus();
    cs = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    release_bus();
    tb_en = 1'b0; cs = 1'b0; rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    sb.delete();
    model_reset();
    check("rst_ready", ready, 0);
    check("rst_ack", ack, 0);
    check("rst_fe", firstempty, INIT_N);
    check("rst_full", memfull, 0);
    cs = 1'b1; memWR = 1'b0;
    #1;
    check("rst_rdreg", databus, 0);
    cs = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int exp);
    int n = 0;
    while (!ready && n < BUDGET) begin
      @(posedge clk); #2; n++;
    end
    check(name, n, exp);
  endtask

  task automatic f_write(input int a, input int d);
    int n = 0;
    f_cs = 1'b1; f_wr = 1'b1; f_addr = ADDR_W'(a); f_drv = DATA_W'(d); f_en = 1'b1;
    while (!f_ready && n < BUDGET) begin
      @(posedge clk); #2; n++;
    end
    check($sformatf("f_accept_%0d", a), f_ready, 1);
    @(posedge clk); #2;
    f_cs = 1'b0; f_wr = 1'b0; f_en = 1'b0;
  endtask

  task automatic f_count_ready(input string name, input int exp);
    int n = 0;
    while (!f_ready && n < BUDGET) begin
      @(posedge clk); #2; n++;
    end
    check(name, n, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdat;
  int                sel;

  initial begin
    @(posedge clk); #2;

    // reset, then a second reset in the middle of INIT
    do_reset();
    repeat (30) begin @(posedge clk); #2; end
    check("init_busy", ready, 0);
    do_reset();
    // a write presented during INIT must be ignored
    cs = 1'b1; memWR = 1'b1; addr = 10; tb_drv = 'hDEAD; tb_en = 1'b1;
    repeat (40) begin @(posedge clk); #2; end
    cs = 1'b0; tb_en = 1'b0; memWR = 1'b0;
    wait_ready("init_len_after_midreset", DEPTH - 1 - 40);
    access(0, 10, '0);
    access(0, 20, '0);

    // clean reset and directed plan
    do_reset();
    wait_ready("init_len", DEPTH - 1);
    check("idle_fe", firstempty, 100);
    check("idle_full", memfull, 0);
    access(0, 5, '0);
    access(0, 150, '0);
    access(0, 191, '0);
    access(1, 100, 'hA5);
    check("fe_101", firstempty, 101);
    access(1, 101, 1);
    access(1, 102, 1);
    access(1, 103, 1);
    check("fe_104", firstempty, 104);
    access(1, 50, '0);
    check("fe_50", firstempty, 50);
    access(1, 0, '0);
    check("fe_still_50", firstempty, 50);
    access(1, 191, 7);
    access(0, 191, '0);
    access(0, 5, '0);
    access(0, 6, '0);
    access(0, 50, '0);
    access(0, 200, '0);
    release_bus();
    cs = 1'b0; memWR = 1'b0;
    #1;
    check("hiz_cs0", databus, zval);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    ra = ADDR_W'(model_fe());
        2:       ra = ADDR_W'(DEPTH - 1);
        3:       ra = ADDR_W'($urandom_range(DEPTH, 255));
        4:       ra = ADDR_W'(DEPTH - 2);
        default: ra = ADDR_W'($urandom_range(0, DEPTH - 2));
      endcase
      rdat = ($urandom_range(0, 2) == 0) ? '0 : DATA_W'($urandom);
      if (sel == 11) idle_cycle();
      else access($urandom_range(0, 1) == 1, int'(ra), rdat);
    end
    release_bus();
    repeat (3) begin @(posedge clk); #2; end
    check("sb_drain", sb.size(), 0);

    // initially-full instance
    f_rst = 1'b1;
    @(posedge clk); #2;
    f_rst = 1'b0;
    check("f_rst_ready", f_ready, 0);
    check("f_rst_fe", f_fe, 191);
    check("f_rst_full", f_full, 1);
    f_count_ready("f_init_len", 191);
    check("f_full_init", f_full, 1);
    f_write(7, 0);
    check("f_fe_7", f_fe, 7);
    check("f_full_clr", f_full, 0);
    check("f_nostall", f_ready, 1);
    f_write(7, 9);
    f_count_ready("f_scan_len", 183);
    check("f_full_set", f_full, 1);
    check("f_fe_191", f_fe, 191);
    f_write(7, 0);
    f_write(7, 9);
    repeat (20) begin @(posedge clk); #2; end
    check("f_mid_scan", f_ready, 0);
    check("f_mid_scan_fe", f_fe, 7);
    f_rst = 1'b1;
    @(posedge clk); #2;
    f_rst = 1'b0;
    check("f_rst2_ready", f_ready, 0);
    check("f_rst2_fe", f_fe, 191);
    check("f_rst2_full", f_full, 1);
    f_count_ready("f_reinit_len", 191);
    f_cs = 1'b1; f_wr = 1'b0; f_addr = 20;
    @(posedge clk); #2;
    @(negedge clk);
    check("f_ack", f_ack, 1);
    check("f_read_20", f_bus, 21);
    #1;
    f_cs = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
